truco_turn_ctrl: RTL
====================

Name: truco_turn_ctrl

Overview:
- Sequences player turns for one truco hand. It consumes per-player debounced button levels and converts them to single-cycle rising-edge events.
- Accepts actions only from the player allowed to act, and tracks card selection and used cards per player.
- Issues card plays to game logic over a valid/ready handshake, and runs the truco raise/accept/fold exchange and stake level.
- Sits between the debounce stage and the scoring/game logic.

Parameters:
- N_PLAYERS, 4, player count; legal values are 2 or 4. Team of player p is p[0].
- PW, $clog2(N_PLAYERS), player index width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a hand; sampled in IDLE only
- first_player  in  PW  leading player; captured with start
- btn_next  in  N_PLAYERS  debounced level; select next card (in TRUCO_WAIT: fold)
- btn_play  in  N_PLAYERS  debounced level; play selected card (in TRUCO_WAIT: accept)
- btn_truco  in  N_PLAYERS  debounced level; call/raise truco
- play_ready  in  1  game logic accepts the play
- cur_player  out  PW  player allowed to act
- sel_card  out  2  selected card index of cur_player, 0..2
- play_valid  out  1  play offer pending
- play_player  out  PW  player of the pending play
- play_card  out  2  card of the pending play
- stake  out  4  hand value: 1, 3, 6, 9 or 12
- truco_pending  out  1  high in TRUCO_WAIT
- hand_done  out  1  one-cycle pulse at end of hand
- hand_fold  out  1  valid with hand_done; 1 = ended by fold
- fold_team  out  1  valid with hand_done when hand_fold=1; team that folded

Behaviour:
- Reset values: all outputs 0, except stake=1. State=IDLE, used mask=0, edge registers=0.
  - A button held through reset release therefore produces one edge on the first clock after release.
- Edge detection: prev_x <= btn_x every cycle, in all states; edge_x = btn_x & ~prev_x. Edges from players other than the expected actor are discarded, not queued.
- IDLE:
  - start=1 -> cur_player=first_player, used mask=0, stake=1, last_raiser_valid=0, play count=0, sel_card=0 -> TURN.
  - start in any other state is ignored.
- TURN, evaluated for p = cur_player only. Priority: truco > play > next.
  - edge_truco[p] with stake<12, and (last_raiser_valid=0 or last_raiser_team != p[0]):
    - latch requester; responder = (p+1) mod N_PLAYERS -> TRUCO_WAIT.
    - Otherwise the edge is ignored.
  - edge_play[p]:
    - play_player=p, play_card=sel_card, play_valid=1 -> ISSUE. A simultaneous next edge is dropped.
  - edge_next[p]:
    - sel_card advances to the next unused card of p, in order 0->1->2->0, skipping used cards.
    - If only the current card is unused, sel_card is unchanged.
- ISSUE:
  - play_valid, play_player and play_card hold stable until a cycle with play_ready=1.
  - In that cycle: mark the card used, increment play count, clear play_valid on the next edge.
  - If play count reaches 3*N_PLAYERS: hand_done=1, hand_fold=0 -> IDLE.
  - Else cur_player=(p+1) mod N_PLAYERS, sel_card = lowest unused card of the new player -> TURN.
  - Latency from the play edge to play_valid is 1 cycle. All button edges are ignored in ISSUE.
- TRUCO_WAIT: truco_pending=1; cur_player shows the responder.
  - Responder edge_play (accept):
    - stake steps 1->3->6->9->12; last_raiser_team = requester team; last_raiser_valid=1.
    - cur_player restored to requester; sel_card unchanged -> TURN.
  - Responder edge_next (fold):
    - hand_done=1, hand_fold=1, fold_team = responder team -> IDLE. stake is held until the next start.
  - If accept and fold edges arrive in the same cycle, accept wins. edge_truco from the responder is ignored.
- hand_done and hand_fold are exactly one cycle. hand_fold and fold_team hold until the next hand_done.
- Asserting rst in any state immediately returns all outputs and state to reset values. A pending play is dropped and no hand_done is emitted.

Test Plan:
- Reset, start with first_player=2, N=4; player 2 presses play; play_ready=1 on the 3rd cycle -> play_valid held 3 cycles with play_player=2 and play_card=0; then cur_player=3, sel_card=0.
- Player 1 presses next 4 times while cur_player=0 -> sel_card stays 0. Player 0 presses next 4 times with card 1 used -> sel_card sequence 2,0,2,0.
- Full hand, play_ready tied high, 12 plays -> single-cycle hand_done, hand_fold=0; state IDLE; a further play edge produces no play_valid.
- Player 0 calls truco, player 1 accepts -> stake=3, cur_player=0. A second truco from player 0 is ignored; player 2's later truco on their turn is ignored (same team as 0). Player 1's truco on their turn -> TRUCO_WAIT; accept -> stake=6.
- Truco from player 3, responder 0 presses next -> hand_done=1, hand_fold=1, fold_team=0, stake stays 3.
- rst asserted mid-ISSUE with play_valid=1 -> play_valid=0 and stake=1 asynchronously; button held across release yields exactly one edge.

Source files
------------

// File: rtl/truco_turn_ctrl.sv
// Turn sequencer for one truco hand: button edge detection, actor gating,
// card selection/usage, play handshake to game logic and truco stake exchange.
module truco_turn_ctrl #(
    parameter int N_PLAYERS = 4,
    parameter int PW        = $clog2(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PW-1:0]        first_player,
    input  logic [N_PLAYERS-1:0] btn_next,
    input  logic [N_PLAYERS-1:0] btn_play,
    input  logic [N_PLAYERS-1:0] btn_truco,
    input  logic                 play_ready,
    output logic [PW-1:0]        cur_player,
    output logic [1:0]           sel_card,
    output logic                 play_valid,
    output logic [PW-1:0]        play_player,
    output logic [1:0]           play_card,
    output logic [3:0]           stake,
    output logic                 truco_pending,
    output logic                 hand_done,
    output logic                 hand_fold,
    output logic                 fold_team
);

    localparam int CW = $clog2(3 * N_PLAYERS + 1);
    localparam logic [CW-1:0] LAST_PLAY = CW'(3 * N_PLAYERS);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_TURN       = 2'd1,
        S_ISSUE      = 2'd2,
        S_TRUCO_WAIT = 2'd3
    } state_t;

    state_t                      state_r, state_s;
    logic [N_PLAYERS-1:0]        prev_next_r, prev_play_r, prev_truco_r;
    logic [N_PLAYERS-1:0]        edge_next_s, edge_play_s, edge_truco_s;
    logic [N_PLAYERS-1:0][2:0]   used_r, used_s;
    logic [CW-1:0]               cnt_r, cnt_s;
    logic [PW-1:0]               cur_player_r, cur_player_s;
    logic [PW-1:0]               requester_r, requester_s;
    logic [PW-1:0]               play_player_r, play_player_s;
    logic [PW-1:0]               nxt_player_s;
    logic [1:0]                  sel_card_r, sel_card_s;
    logic [1:0]                  play_card_r, play_card_s;
    logic [3:0]                  stake_r, stake_s;
    logic                        lr_valid_r, lr_valid_s;
    logic                        lr_team_r, lr_team_s;
    logic                        play_valid_r, play_valid_s;
    logic                        truco_pending_r, truco_pending_s;
    logic                        hand_done_r, hand_done_s;
    logic                        hand_fold_r, hand_fold_s;
    logic                        fold_team_r, fold_team_s;

    // Next unused card after cur in cyclic order 0->1->2->0; keeps cur if none.
    function automatic logic [1:0] next_unused(input logic [2:0] used, input logic [1:0] cur);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (!used[c1]) begin
            return c1;
        end else if (!used[c2]) begin
            return c2;
        end else begin
            return cur;
        end
    endfunction

    function automatic logic [1:0] lowest_unused(input logic [2:0] used);
        if (!used[0]) begin
            return 2'd0;
        end else if (!used[1]) begin
            return 2'd1;
        end else if (!used[2]) begin
            return 2'd2;
        end else begin
            return 2'd0;
        end
    endfunction

    function automatic logic [3:0] raise_stake(input logic [3:0] s);
        case (s)
            4'd1:    return 4'd3;
            4'd3:    return 4'd6;
            4'd6:    return 4'd9;
            default: return 4'd12;
        endcase
    endfunction

    assign edge_next_s  = btn_next  & ~prev_next_r;
    assign edge_play_s  = btn_play  & ~prev_play_r;
    assign edge_truco_s = btn_truco & ~prev_truco_r;
    assign nxt_player_s = play_player_r + PW'(1);

    // Next-state and next-output computation for the turn FSM.
    always_comb begin
        state_s         = state_r;
        used_s          = used_r;
        cnt_s           = cnt_r;
        cur_player_s    = cur_player_r;
        requester_s     = requester_r;
        play_player_s   = play_player_r;
        sel_card_s      = sel_card_r;
        play_card_s     = play_card_r;
        stake_s         = stake_r;
        lr_valid_s      = lr_valid_r;
        lr_team_s       = lr_team_r;
        play_valid_s    = play_valid_r;
        hand_done_s     = 1'b0;
        hand_fold_s     = hand_fold_r;
        fold_team_s     = fold_team_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    cur_player_s = first_player;
                    used_s       = '0;
                    cnt_s        = '0;
                    stake_s      = 4'd1;
                    lr_valid_s   = 1'b0;
                    sel_card_s   = 2'd0;
                    state_s      = S_TURN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TURN: begin
                // A truco call only outranks play/next when it is legal.
                if (edge_truco_s[cur_player_r] && (stake_r != 4'd12) &&
                    (!lr_valid_r || (lr_team_r != cur_player_r[0]))) begin
                    requester_s  = cur_player_r;
                    cur_player_s = cur_player_r + PW'(1);
                    state_s      = S_TRUCO_WAIT;
                end else if (edge_play_s[cur_player_r]) begin
                    play_player_s = cur_player_r;
                    play_card_s   = sel_card_r;
                    play_valid_s  = 1'b1;
                    state_s       = S_ISSUE;
                end else if (edge_next_s[cur_player_r]) begin
                    sel_card_s = next_unused(used_r[cur_player_r], sel_card_r);
                end else begin
                    state_s = S_TURN;
                end
            end
            S_ISSUE: begin
                if (play_ready) begin
                    used_s[play_player_r][play_card_r] = 1'b1;
                    cnt_s        = cnt_r + CW'(1);
                    play_valid_s = 1'b0;
                    if (cnt_s == LAST_PLAY) begin
                        hand_done_s = 1'b1;
                        hand_fold_s = 1'b0;
                        state_s     = S_IDLE;
                    end else begin
                        cur_player_s = nxt_player_s;
                        sel_card_s   = lowest_unused(used_r[nxt_player_s]);
                        state_s      = S_TURN;
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_TRUCO_WAIT: begin
                if (edge_play_s[cur_player_r]) begin
                    stake_s      = raise_stake(stake_r);
                    lr_team_s    = requester_r[0];
                    lr_valid_s   = 1'b1;
                    cur_player_s = requester_r;
                    state_s      = S_TURN;
                end else if (edge_next_s[cur_player_r]) begin
                    hand_done_s = 1'b1;
                    hand_fold_s = 1'b1;
                    fold_team_s = cur_player_r[0];
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_TRUCO_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        truco_pending_s = (state_s == S_TRUCO_WAIT);
    end

    // State, edge-history and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_IDLE;
            prev_next_r     <= '0;
            prev_play_r     <= '0;
            prev_truco_r    <= '0;
            used_r          <= '0;
            cnt_r           <= '0;
            cur_player_r    <= '0;
            requester_r     <= '0;
            play_player_r   <= '0;
            sel_card_r      <= 2'd0;
            play_card_r     <= 2'd0;
            stake_r         <= 4'd1;
            lr_valid_r      <= 1'b0;
            lr_team_r       <= 1'b0;
            play_valid_r    <= 1'b0;
            truco_pending_r <= 1'b0;
            hand_done_r     <= 1'b0;
            hand_fold_r     <= 1'b0;
            fold_team_r     <= 1'b0;
        end else begin
            state_r         <= state_s;
            prev_next_r     <= btn_next;
            prev_play_r     <= btn_play;
            prev_truco_r    <= btn_truco;
            used_r          <= used_s;
            cnt_r           <= cnt_s;
            cur_player_r    <= cur_player_s;
            requester_r     <= requester_s;
            play_player_r   <= play_player_s;
            sel_card_r      <= sel_card_s;
            play_card_r     <= play_card_s;
            stake_r         <= stake_s;
            lr_valid_r      <= lr_valid_s;
            lr_team_r       <= lr_team_s;
            play_valid_r    <= play_valid_s;
            truco_pending_r <= truco_pending_s;
            hand_done_r     <= hand_done_s;
            hand_fold_r     <= hand_fold_s;
            fold_team_r     <= fold_team_s;
        end
    end

    assign cur_player    = cur_player_r;
    assign sel_card      = sel_card_r;
    assign play_valid    = play_valid_r;
    assign play_player   = play_player_r;
    assign play_card     = play_card_r;
    assign stake         = stake_r;
    assign truco_pending = truco_pending_r;
    assign hand_done     = hand_done_r;
    assign hand_fold     = hand_fold_r;
    assign fold_team     = fold_team_r;

endmodule
